gpio_wb_arbiter: RTL and testbench
==================================

Name: gpio_wb_arbiter

Overview:
Two-master to one-slave Wishbone arbiter that shares the user-area GPIO peripheral between the Caravel management Wishbone (master 0) and the rvj1 core data bus (master 1). Grants are round-robin and held for the whole bus cycle. A per-transaction watchdog aborts any access the slave fails to acknowledge, so a non-acking address (e.g. an unserviced read) cannot hang either master.

Parameters:
TIMEOUT_CYCLES, 16, cycles of stb-without-ack before the arbiter aborts and self-acks (min 2)
TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned to the master on an aborted access
CNT_WIDTH, 5, watchdog counter width; must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
m0_adr_i, m0_dat_i  in  32 each  master 0 address / write data
m0_sel_i  in  4  master 0 byte selects
m0_ack_o  out  1  master 0 ack
m0_dat_o  out  32  master 0 read data
m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i, m1_ack_o, m1_dat_o  same as m0, for master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to GPIO slave
s_adr_o, s_dat_o  out  32 each  to GPIO slave
s_sel_o  out  4  to GPIO slave
s_ack_i  in  1  slave ack
s_dat_i  in  32  slave read data
grant_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 0 when idle
timeout_o  out  1  sticky flag: an access was aborted
timeout_clr_i  in  1  synchronous clear of timeout_o

Behaviour:
- Reset is asynchronous on rst_i high:
  - state=IDLE, last_grant=1 (so m0 wins the first tie), counter=0, timeout_o=0.
  - All s_* outputs, m*_ack_o and m*_dat_o read 0; grant_o=0.
- States: IDLE, GNT0, GNT1.
- IDLE transitions:
  - m0_cyc_i only -> GNT0.
  - m1_cyc_i only -> GNT1.
  - Both asserted -> the master not equal to last_grant.
  - Neither -> stay IDLE.
  - Grant is registered. A request first seen in cycle N appears on s_* in cycle N+1.
- GNTx routing:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are muxed combinationally from master x.
  - mx_ack_o = s_ack_i and mx_dat_o = s_dat_i.
  - The other master sees ack=0 and dat=0.
- GNTx exit:
  - When mx_cyc_i falls, go to IDLE and set last_grant=x.
  - There is always one IDLE cycle between grants.
  - The grant is held across multiple stb beats while cyc stays high.
- Watchdog counter, in GNTx:
  - Counts while mx_stb_i=1 and s_ack_i=0.
  - Clears to 0 on s_ack_i, on mx_stb_i=0, and in IDLE.
- Watchdog abort: when the counter equals TIMEOUT_CYCLES-1 and s_ack_i=0, that cycle:
  - mx_ack_o=1 and mx_dat_o=TIMEOUT_DATA.
  - s_cyc_o=0 and s_stb_o=0 (forced abort of the slave).
  - timeout_o is set on the next edge; counter clears to 0.
  - The grant is kept; the master releases cyc normally.
- Simultaneous events:
  - s_ack_i in the abort cycle: the real ack wins, no abort, timeout_o unchanged.
  - timeout_clr_i with a new abort in the same cycle: set wins.
- Master drops cyc mid-access (no ack yet): s_* deassert combinationally the same cycle, FSM goes to IDLE, counter clears. A late s_ack_i is ignored and not forwarded.
- Reset mid-transaction: immediate return to reset values; no ack is generated.
- Only one ack per stb beat reaches a master. The block adds no buffering.

Test Plan:
- Reset, then m0 write adr=0x3001_0000 dat=0x00AB_CDEF; slave acks 1 cycle after stb -> s_* active cycle after request, m0_ack_o pulses once, grant_o=01, m1 outputs 0.
- m0 and m1 assert cyc in the same cycle, repeatedly; each master drops cyc after its ack -> grant order m0, m1, m0, m1 with exactly one IDLE cycle (grant_o=00) between grants.
- m1 read adr=0x3001_0001; slave never acks, TIMEOUT_CYCLES=16 -> m1_ack_o=1 with m1_dat_o=0xDEAD_BEEF exactly 16 cycles after stb first seen on s_stb_o, s_cyc_o=0 that cycle, timeout_o=1 next cycle; then timeout_clr_i pulse -> timeout_o=0.
- Slave acks on the same cycle the counter hits 15 -> normal ack with s_dat_i passed through, timeout_o stays 0.
- m0 holds cyc for 3 stb beats while m1 requests -> m1 starves until m0 drops cyc, then is granted after one IDLE cycle.
- rst_i asserted asynchronously mid-access (between clock edges) -> s_cyc_o, m0_ack_o, grant_o go 0 immediately; after release the first tie goes to m0.

Source files
------------

// File: rtl/gpio_wb_arbiter.sv
// gpio_wb_arbiter
//   Two-master to one-slave Wishbone arbiter sharing the user-area GPIO
//   peripheral between the Caravel management bus (master 0) and the rvj1
//   core data bus (master 1). Grants are round-robin, registered, and held
//   for the whole bus cycle (while the granted master keeps cyc high).
//   A per-transaction watchdog aborts any beat the slave never acknowledges
//   by self-acking the master with TIMEOUT_DATA and dropping the slave
//   strobe, so an unserviced address cannot hang either master.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   m0_* / m1_*            Wishbone slave-side ports for master 0 / master 1
//   s_*                    Wishbone master-side port to the GPIO slave
//   grant_o                one-hot current grant (bit0 = m0, bit1 = m1), 0 idle
//   timeout_o              sticky flag: an access was aborted
//   timeout_clr_i          synchronous clear of timeout_o (a new abort wins)
module gpio_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Counter value on which an unacknowledged beat is aborted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic                 last_grant, last_grant_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 timeout_nxt;

  logic                 sel_cyc, sel_stb, sel_we;
  logic [31:0]          sel_adr, sel_dat;
  logic [3:0]           sel_sel;
  logic                 abort;
  logic                 master_ack;
  logic [31:0]          master_dat;

  // Pick the bus signals of whichever master currently holds the grant.
  // In IDLE everything is zero so the slave sees a quiet bus.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    unique case (state)
      GNT0: begin
        sel_cyc = m0_cyc_i;
        sel_stb = m0_stb_i;
        sel_we  = m0_we_i;
        sel_adr = m0_adr_i;
        sel_dat = m0_dat_i;
        sel_sel = m0_sel_i;
      end
      GNT1: begin
        sel_cyc = m1_cyc_i;
        sel_stb = m1_stb_i;
        sel_we  = m1_we_i;
        sel_adr = m1_adr_i;
        sel_dat = m1_dat_i;
        sel_sel = m1_sel_i;
      end
      default: ;
    endcase
  end

  // A real slave ack in the last watchdog cycle beats the abort.
  assign abort = sel_cyc && sel_stb && !s_ack_i && (cnt == CNT_LAST);

  // Strobe is qualified with cyc so a master that drops cyc mid-access
  // releases the slave in the same cycle; the abort kills both lines.
  assign s_cyc_o = sel_cyc & ~abort;
  assign s_stb_o = sel_cyc & sel_stb & ~abort;
  assign s_we_o  = sel_we;
  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;
  assign s_sel_o = sel_sel;

  // Acks are only forwarded to a master that still owns an active beat, so
  // a late slave ack after the master gave up is swallowed.
  assign master_ack = (sel_cyc & sel_stb & s_ack_i) | abort;
  assign master_dat = abort ? TIMEOUT_DATA : s_dat_i;

  assign m0_ack_o = (state == GNT0) & master_ack;
  assign m1_ack_o = (state == GNT1) & master_ack;
  assign m0_dat_o = (state == GNT0) ? master_dat : '0;
  assign m1_dat_o = (state == GNT1) ? master_dat : '0;

  assign grant_o  = {state == GNT1, state == GNT0};

  // Round-robin arbitration: on a tie the master that did not own the last
  // grant wins. Leaving a grant always passes through IDLE for one cycle.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_grant ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counts consecutive stb-without-ack cycles of the granted beat
  // and restarts on any ack, on stb/cyc low, on an abort and in IDLE.
  always_comb begin
    cnt_nxt = '0;
    if (sel_cyc && sel_stb && !s_ack_i && !abort) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Sticky abort flag; a new abort has priority over the clear.
  always_comb begin
    timeout_nxt = timeout_o;
    if (abort) begin
      timeout_nxt = 1'b1;
    end else if (timeout_clr_i) begin
      timeout_nxt = 1'b0;
    end
  end

  // State registers. last_grant resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      timeout_o  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// tb_gpio_wb_arbiter
//   Directed bench for gpio_wb_arbiter. A small slave model answers beats
//   after a programmable number of strobe cycles; expected acks are queued
//   when a master starts an access and popped by a monitor on every ack.
module tb_gpio_wb_arbiter;

  typedef struct packed {
    logic        m;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat;
  logic [3:0]  m0_sel;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat;
  logic [3:0]  m1_sel;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic        timeout_o;
  logic        timeout_clr;

  logic        s_ack_reg;
  logic        ack_force;
  int unsigned ack_delay;
  int unsigned stb_age;
  logic [31:0] s_rdata;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  gpio_wb_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m0_cyc_i      (m0_cyc),
    .m0_stb_i      (m0_stb),
    .m0_we_i       (m0_we),
    .m0_adr_i      (m0_adr),
    .m0_dat_i      (m0_dat),
    .m0_sel_i      (m0_sel),
    .m0_ack_o      (m0_ack_o),
    .m0_dat_o      (m0_dat_o),
    .m1_cyc_i      (m1_cyc),
    .m1_stb_i      (m1_stb),
    .m1_we_i       (m1_we),
    .m1_adr_i      (m1_adr),
    .m1_dat_i      (m1_dat),
    .m1_sel_i      (m1_sel),
    .m1_ack_o      (m1_ack_o),
    .m1_dat_o      (m1_dat_o),
    .s_cyc_o       (s_cyc_o),
    .s_stb_o       (s_stb_o),
    .s_we_o        (s_we_o),
    .s_adr_o       (s_adr_o),
    .s_dat_o       (s_dat_o),
    .s_sel_o       (s_sel_o),
    .s_ack_i       (s_ack_i),
    .s_dat_i       (s_dat_i),
    .grant_o       (grant_o),
    .timeout_o     (timeout_o),
    .timeout_clr_i (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data the slave model returns for a given address.
  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Slave model: acks on the cycle after the strobe has been seen for
  // ack_delay consecutive cycles; ack_delay of 0 means never ack.
  // ack_force lets the bench inject a stray ack.
  assign s_ack_i = s_ack_reg | ack_force;
  assign s_dat_i = s_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_reg <= 1'b0;
      stb_age   <= 0;
      s_rdata   <= '0;
    end else if (s_cyc_o && s_stb_o && !s_ack_reg) begin
      if (ack_delay != 0 && stb_age + 1 == ack_delay) begin
        s_ack_reg <= 1'b1;
        s_rdata   <= rdata(s_adr_o);
      end
      stb_age <= stb_age + 1;
    end else begin
      s_ack_reg <= 1'b0;
      stb_age   <= 0;
    end
  end

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one master's bus signals.
  task automatic applyStimulus(input logic m, input logic cyc, input logic stb,
                               input logic we, input logic [31:0] adr,
                               input logic [31:0] dat);
    if (m) begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat;
      m1_sel = 4'hF;
    end else begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat;
      m0_sel = 4'hF;
    end
  endtask

  task automatic expect_ack(input logic m, input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for an ack on master m; n is the number of negedges
  // sampled until it appeared.
  task automatic wait_ack(input logic m, input int bound, output int n);
    n = 0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if ((m ? m1_ack_o : m0_ack_o) === 1'b1) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL wait_ack_m%0d: observed no ack in %0d cycles expected ack", m, bound);
    end
  endtask

  // Scoreboard monitor: every ack must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m0_ack_o || m1_ack_o)) begin
      if (m0_ack_o && m1_ack_o) begin
        checks++;
        errors++;
        $error("[TB] FAIL sb_dual_ack: observed both acks expected one");
      end else if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL sb_unexpected_ack: observed ack on m%0d expected none", m1_ack_o);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_ack_master", 32'(m1_ack_o), 32'(e.m));
        checkOutput("sb_ack_data", m1_ack_o ? m1_dat_o : m0_dat_o, e.d);
      end
    end
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  localparam logic [31:0] A_TIE0 = 32'h3001_0050;
  localparam logic [31:0] A_TIE1 = 32'h3001_0060;

  initial begin
    int   n;
    int   idle;
    logic got;
    logic win;
    logic [31:0] adr;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    timeout_clr = 1'b0;
    ack_force   = 1'b0;
    ack_delay   = 1;

    // Reset values
    @(negedge clk);
    checkOutput("rst_grant", 32'(grant_o), 32'h0);
    checkOutput("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("rst_s_adr", s_adr_o, 32'h0);
    checkOutput("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    checkOutput("rst_m0_dat", m0_dat_o, 32'h0);
    checkOutput("rst_timeout", 32'(timeout_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single m0 write, slave acks one cycle after the strobe
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3001_0000, 32'h00AB_CDEF);
    expect_ack(1'b0, rdata(32'h3001_0000));
    @(negedge clk);
    checkOutput("t1_req_cycle_s_cyc", 32'(s_cyc_o), 32'h0);
    @(negedge clk);
    checkOutput("t1_grant", 32'(grant_o), 32'h1);
    checkOutput("t1_s_cyc", 32'(s_cyc_o), 32'h1);
    checkOutput("t1_s_we", 32'(s_we_o), 32'h1);
    checkOutput("t1_s_adr", s_adr_o, 32'h3001_0000);
    checkOutput("t1_s_dat", s_dat_o, 32'h00AB_CDEF);
    checkOutput("t1_s_sel", 32'(s_sel_o), 32'hF);
    checkOutput("t1_m1_ack", 32'(m1_ack_o), 32'h0);
    checkOutput("t1_m1_dat", m1_dat_o, 32'h0);
    wait_ack(1'b0, 8, n);
    checkOutput("t1_ack_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t1_single_ack", 32'(m0_ack_o), 32'h0);
    checkOutput("t1_release_s_cyc", 32'(s_cyc_o), 32'h0);
    @(negedge clk);
    checkOutput("t1_idle", 32'(grant_o), 32'h0);

    // m1 read that the slave never acks: watchdog abort
    @(posedge clk); #1;
    ack_delay = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h3001_0001, '0);
    expect_ack(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("t3_req_cycle_s_stb", 32'(s_stb_o), 32'h0);
    wait_ack(1'b1, 40, n);
    checkOutput("t3_abort_latency", 32'(n), 32'd16);
    checkOutput("t3_abort_dat", m1_dat_o, 32'hDEAD_BEEF);
    checkOutput("t3_abort_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("t3_abort_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("t3_timeout_not_yet", 32'(timeout_o), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t3_timeout_set", 32'(timeout_o), 32'h1);
    checkOutput("t3_no_second_ack", 32'(m1_ack_o), 32'h0);
    @(posedge clk); #1;
    timeout_clr = 1'b1;
    @(negedge clk);
    checkOutput("t3_timeout_clr_sync", 32'(timeout_o), 32'h1);
    @(posedge clk); #1;
    timeout_clr = 1'b0;
    @(negedge clk);
    checkOutput("t3_timeout_cleared", 32'(timeout_o), 32'h0);

    // Slave acks exactly in the would-be abort cycle: real ack wins
    @(posedge clk); #1;
    ack_delay = 15;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h3001_0004, '0);
    expect_ack(1'b0, rdata(32'h3001_0004));
    @(negedge clk);
    wait_ack(1'b0, 40, n);
    checkOutput("t4_ack_latency", 32'(n), 32'd16);
    checkOutput("t4_ack_dat", m0_dat_o, rdata(32'h3001_0004));
    checkOutput("t4_no_abort_s_cyc", 32'(s_cyc_o), 32'h1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t4_timeout_stays", 32'(timeout_o), 32'h0);

    // m0 holds cyc over three beats while m1 waits
    @(posedge clk); #1;
    ack_delay = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3001_0010, 32'h1111_0000);
    expect_ack(1'b0, rdata(32'h3001_0010));
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h3001_0020, 32'h2222_0000);
    for (int b = 0; b < 3; b++) begin
      wait_ack(1'b0, 8, n);
      checkOutput("t5_grant_beat", 32'(grant_o), 32'h1);
      @(posedge clk); #1;
      m0_stb = 1'b0;
      @(negedge clk);
      checkOutput("t5_hold_grant", 32'(grant_o), 32'h1);
      checkOutput("t5_m1_starved", 32'(m1_ack_o), 32'h0);
      if (b < 2) begin
        @(posedge clk); #1;
        adr = 32'h3001_0010 + 32'(4 * (b + 1));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, adr, 32'h1111_0000 + 32'(b));
        expect_ack(1'b0, rdata(adr));
      end
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    expect_ack(1'b1, rdata(32'h3001_0020));
    @(negedge clk);
    checkOutput("t5_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    @(negedge clk);
    checkOutput("t5_idle_gap", 32'(grant_o), 32'h0);
    @(negedge clk);
    checkOutput("t5_m1_granted", 32'(grant_o), 32'h2);
    checkOutput("t5_m1_adr", s_adr_o, 32'h3001_0020);
    wait_ack(1'b1, 8, n);
    checkOutput("t5_m1_ack_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);

    // Master drops cyc before any ack; a stray ack must not be forwarded
    @(posedge clk); #1;
    ack_delay = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h3001_0030, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t7_active_s_cyc", 32'(s_cyc_o), 32'h1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    ack_force = 1'b1;
    @(negedge clk);
    checkOutput("t7_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("t7_drop_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("t7_late_ack_blocked", 32'(m0_ack_o), 32'h0);
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(negedge clk);
    checkOutput("t7_idle", 32'(grant_o), 32'h0);

    // Asynchronous reset in the middle of an access
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3001_0040, 32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_pre_reset_s_cyc", 32'(s_cyc_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("t6_async_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("t6_async_grant", 32'(grant_o), 32'h0);
    checkOutput("t6_async_m0_ack", 32'(m0_ack_o), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Simultaneous requests after reset: m0, m1, m0, m1 with one IDLE gap
    @(posedge clk); #1;
    ack_delay = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, A_TIE0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, A_TIE1, '0);
    for (int i = 0; i < 4; i++) begin
      win = (i % 2 == 1);
      expect_ack(win, rdata(win ? A_TIE1 : A_TIE0));
      idle = 0;
      got  = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        if (grant_o == 2'b00) idle++;
        else got = 1'b1;
      end
      checkOutput("t2_grant_order", 32'(grant_o), win ? 32'h2 : 32'h1);
      checkOutput("t2_idle_gap", 32'(idle), 32'd1);
      wait_ack(win, 8, n);
      @(posedge clk); #1;
      applyStimulus(win, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      @(posedge clk); #1;
      applyStimulus(win, 1'b1, 1'b1, 1'b0, win ? A_TIE1 : A_TIE0, '0);
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
